// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the framed UART transmitter.
// State encoding, frame geometry and byte-count helper.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_SEND = 3'd2,
      S_WAIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam int UART_FRAME_BITS = 10;

   function automatic int frame_bytes(
      input int num_words,
      input int word_bytes,
      input int checksum_en
   );
      return 1 + num_words * word_bytes + checksum_en;
   endfunction

endpackage

// File: rtl/uart_frame_tx_byte.sv
// Single-byte UART serializer: start bit, 8 data bits LSB-first, stop bit.
// Accepts byte_valid only while idle; the start bit is on the line the cycle after.
module uart_byte_tx #(
   parameter int CLKS_PER_BIT = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       txd,
   output logic       busy
);
   import uart_frame_pkg::*;

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(UART_FRAME_BITS);
   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(UART_FRAME_BITS - 1);

   logic [UART_FRAME_BITS-1:0] sh_q;
   logic [CW-1:0]              clk_cnt_q;
   logic [BW-1:0]              bit_cnt_q;
   logic                       busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q      <= '1;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         busy_q    <= 1'b0;
      end else if (!busy_q) begin
         if (byte_valid) begin
            sh_q      <= {1'b1, byte_data, 1'b0};
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
         end
      end else if (clk_cnt_q == CLK_LAST) begin
         clk_cnt_q <= '0;
         sh_q      <= {1'b1, sh_q[UART_FRAME_BITS-1:1]};
         if (bit_cnt_q == BIT_LAST) begin
            busy_q <= 1'b0;
         end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
         end
      end else begin
         clk_cnt_q <= clk_cnt_q + 1'b1;
      end
   end

   assign txd  = busy_q ? sh_q[0] : 1'b1;
   assign busy = busy_q;

endmodule

// File: rtl/uart_frame_tx.sv
// Framed UART transmitter: sync byte, payload MSB-first, optional checksum.
// Rising edge of tx_start latches the payload; tx_done high while idle.
module uart_frame_tx #(
   parameter int         CLK_HZ      = 10000000,
   parameter int         BAUD        = 500000,
   parameter int         NUM_WORDS   = 1,
   parameter int         WORD_BYTES  = 2,
   parameter logic [7:0] SYNC_BYTE   = 8'h00,
   parameter int         CHECKSUM_EN = 0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              tx_start,
   input  logic [NUM_WORDS*WORD_BYTES*8-1:0] data_in,
   output logic                              uart_txd,
   output logic                              tx_done,
   output logic                              tx_overrun
);
   import uart_frame_pkg::*;

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int NB   = NUM_WORDS * WORD_BYTES;
   localparam int FB   = frame_bytes(NUM_WORDS, WORD_BYTES, CHECKSUM_EN);
   localparam int CNTW = $clog2(FB);

   state_t            state_q;
   state_t            state_d;
   logic              start_q;
   logic              done_q;
   logic              ovr_q;
   logic [NB*8-1:0]   shift_q;
   logic [7:0]        byte_q;
   logic [7:0]        csum_q;
   logic [CNTW-1:0]   cnt_q;
   logic [7:0]        top_byte;
   logic              start_edge;
   logic              accept;
   logic              last_is_csum;
   logic              core_busy;
   logic              byte_valid;
   logic              load_sync;
   logic              adv;
   logic              done_set;

   assign start_edge   = tx_start & ~start_q;
   assign accept       = start_edge & done_q;
   assign top_byte     = shift_q[NB*8-1 -: 8];
   assign last_is_csum = (CHECKSUM_EN != 0) && (cnt_q == CNTW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      byte_valid = 1'b0;
      load_sync  = 1'b0;
      adv        = 1'b0;
      done_set   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_LOAD;
         end
         S_LOAD: begin
            load_sync = 1'b1;
            state_d   = S_SEND;
         end
         S_SEND: begin
            byte_valid = 1'b1;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (!core_busy) begin
               if (cnt_q != '0) begin
                  adv     = 1'b1;
                  state_d = S_SEND;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            done_set = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // cnt_q counts bytes still to follow the one currently in byte_q
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= 1'b0;
         done_q  <= 1'b1;
         ovr_q   <= 1'b0;
         shift_q <= '0;
         byte_q  <= '0;
         csum_q  <= '0;
         cnt_q   <= '0;
      end else begin
         start_q <= tx_start;
         ovr_q   <= start_edge & ~done_q;
         if (accept) begin
            done_q  <= 1'b0;
            shift_q <= data_in;
            csum_q  <= '0;
            cnt_q   <= CNTW'(FB - 1);
         end else if (done_set) begin
            done_q <= 1'b1;
         end
         if (load_sync) byte_q <= SYNC_BYTE;
         if (adv) begin
            cnt_q <= cnt_q - 1'b1;
            if (last_is_csum) begin
               byte_q <= csum_q;
            end else begin
               byte_q  <= top_byte;
               csum_q  <= csum_q + top_byte;
               shift_q <= shift_q << 8;
            end
         end
      end
   end

   uart_byte_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk       (clk),
      .rst_n     (rst_n),
      .byte_valid(byte_valid),
      .byte_data (byte_q),
      .txd       (uart_txd),
      .busy      (core_busy)
   );

   assign tx_done    = done_q;
   assign tx_overrun = ovr_q;

endmodule
